// File: rtl/down_counter64_pkg.sv
// down_counter64_pkg: shared width and FSM state type for the down counter.
package down_counter64_pkg;
   localparam int DCNT_WIDTH = 64;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/dcnt_core.sv
// dcnt_core: count register with load, saturating decrement and hold, plus a zero flag.
module dcnt_core #(parameter int WIDTH = 64) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             dec,
   output logic [WIDTH-1:0] cnt,
   output logic             zero
);
   assign zero = cnt == '0;
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (dec && !zero) cnt <= cnt - WIDTH'(1);
endmodule

// File: rtl/down_counter64.sv
// down_counter64: loadable countdown timer with one-cycle terminal-count pulse.
// Define DOWN_COUNTER64_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module down_counter64
   #(parameter int WIDTH = down_counter64_pkg::DCNT_WIDTH) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             busy
);
   import down_counter64_pkg::*;
`ifdef DOWN_COUNTER64_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   state_t state;
   logic [WIDTH-1:0] reload_q;
   logic zero, run, reload, dec, last;
   assign run = state == RUN;
   assign last = en && out == WIDTH'(1);
   // In auto-reload, a zero count while still running is the cycle after tc.
   assign reload = AUTO && run && zero && !stop;
   assign dec = run && en && !load && !stop;
   dcnt_core #(.WIDTH(WIDTH)) u_core (
      .clk(clk), .rst(rst), .ld(load || reload), .ld_val(load ? load_val : reload_q),
      .dec(dec), .cnt(out), .zero(zero)
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         tc <= 1'b0;
         busy <= 1'b0;
         reload_q <= '0;
      end else if (load) begin
         reload_q <= load_val;
         state <= IDLE;
         tc <= 1'b0;
         busy <= 1'b0;
      end else if (stop) begin
         state <= IDLE;
         tc <= 1'b0;
         busy <= 1'b0;
      end else case (state)
         IDLE: begin
            tc <= start && zero;
            if (start && !zero) begin
               state <= RUN;
               busy <= 1'b1;
            end
         end
         RUN: begin
            tc <= last;
            if (last && (!AUTO || reload_q == '0)) begin
               state <= DONE;
               busy <= 1'b0;
            end
         end
         default: begin
            state <= IDLE;
            tc <= 1'b0;
            busy <= 1'b0;
         end
      endcase
endmodule

// File: tb/tb_down_counter64.sv
// tb_down_counter64: scoreboard bench against a behavioural countdown model.
module tb_down_counter64;
   localparam int W = 64;
`ifdef DOWN_COUNTER64_AUTO_RELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   typedef struct packed {logic [W-1:0] out; logic tc; logic busy;} exp_t;
   logic clk = 1'b0;
   logic rst, load, start, stop, en, tc, busy;
   logic [W-1:0] load_val, out;
   exp_t q[$];
   int checks = 0, errors = 0;
   logic [W-1:0] m_out, m_rl;
   bit m_run, m_done, m_tc;
   always #5 clk = ~clk;
   down_counter64 dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .stop(stop), .en(en), .out(out), .tc(tc), .busy(busy)
   );
   task automatic step(input bit r, l, input logic [W-1:0] v, input bit s, p, e);
      rst = r; load = l; load_val = v; start = s; stop = p; en = e;
      if (r) begin
         m_out = '0; m_rl = '0; m_run = 0; m_done = 0; m_tc = 0;
      end else if (l) begin
         m_out = v; m_rl = v; m_run = 0; m_done = 0; m_tc = 0;
      end else if (p || m_done) begin
         m_run = 0; m_done = 0; m_tc = 0;
      end else if (!m_run) begin
         m_tc = s && m_out == 0;
         m_run = s && m_out != 0;
      end else if (m_out == 0) begin
         m_out = m_rl; m_tc = 0;
      end else if (e) begin
         m_out = m_out - 1;
         m_tc = m_out == 0;
         if (m_tc && (!AUTO || m_rl == 0)) begin
            m_run = 0; m_done = 1;
         end
      end else m_tc = 0;
      q.push_back({m_out, m_tc, m_run});
      @(posedge clk); #1;
   endtask
   task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] b);
      checks++;
      if (a !== b) begin
         errors++;
         $display("FAIL %s got %h want %h", n, a, b);
      end
   endtask
   initial forever begin
      @(negedge clk);
      if (q.size() > 0) begin
         exp_t x;
         x = q.pop_front();
         checks++;
         if ({out, tc, busy} !== x) begin
            errors++;
            $display("FAIL scoreboard t=%0t got out=%h tc=%b busy=%b want out=%h tc=%b busy=%b",
                     $time, out, tc, busy, x.out, x.tc, x.busy);
         end
      end
   end
   initial begin
      int n;
      repeat (2) step(1, 1, '1, 0, 0, 0);
      chk("reset_out", out, 0);
      chk("reset_tc", W'(tc), 0);
      chk("reset_busy", W'(busy), 0);
      step(0, 1, 5, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      n = 1;
      while (!tc && n < 20) begin
         step(0, 0, 0, 0, 0, 1);
         n++;
      end
      chk("oneshot_latency", W'(n), 6);
      chk("busy_at_tc", W'(busy), W'(AUTO));
      step(0, 1, 10, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      repeat (3) step(0, 0, 0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0, 0, 0);
      chk("pause_out", out, 7);
      chk("pause_busy", W'(busy), 1);
      step(0, 0, 0, 0, 1, 1);
      chk("stop_out", out, 7);
      chk("stop_busy", W'(busy), 0);
      chk("stop_tc", W'(tc), 0);
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      chk("zero_tc", W'(tc), 1);
      chk("zero_busy", W'(busy), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("zero_tc_clear", W'(tc), 0);
      step(0, 1, 9, 1, 0, 1);
      chk("load_start_busy", W'(busy), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("load_start_out", out, 9);
      step(0, 1, '1, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      repeat (3) step(0, 0, 0, 0, 0, 1);
      chk("ones_out", out, 64'hFFFF_FFFF_FFFF_FFFC);
      step(0, 0, 0, 0, 1, 1);
`ifdef DOWN_COUNTER64_AUTO_RELOAD_EN
      step(0, 1, 3, 0, 0, 1);
      step(0, 0, 0, 1, 0, 1);
      n = 0;
      repeat (20) begin
         step(0, 0, 0, 0, 0, 1);
         n += int'(tc);
      end
      chk("auto_tc_count", W'(n), 5);
      step(0, 0, 0, 0, 1, 1);
      chk("auto_stop_busy", W'(busy), 0);
`endif
      for (int i = 0; i < 10000; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) == 0 ? {$urandom, $urandom} : W'($urandom_range(0, 12)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) != 0);
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
